matmul_apb_master: RTL and testbench

- APB initiator that drives the matmul accelerator's APB slave port (register file and SP_NTARGETS scratchpads) from a simple valid/ready command stream.
- The testbench sequencer or an on-chip controller uses it to write operands and the control register, poll status, and read results.
- It executes one APB transfer per command and returns one response per command.
- Adds a PREADY timeout so a hung slave cannot stall the initiator forever.

---
 rtl/matmul_apb_master.sv | 131 +++++++++++++
 tb/tb_matmul_apb_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/matmul_apb_master.sv
// rtl/matmul_apb_master.sv - APB initiator driving the matmul slave port from a valid/ready command stream
module matmul_apb_master #(
    parameter int BUS_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [BUS_WIDTH-1:0]   req_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] req_strb_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   rsp_timeout_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [ADDR_WIDTH-1:0]  paddr_o,
    output logic [BUS_WIDTH-1:0]   pwdata_o,
    output logic [BUS_WIDTH/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [BUS_WIDTH-1:0]   prdata_i,
    input  logic                   pslverr_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    state_t                   state_q, state_d;
    logic                     cap_req, cap_rsp, to_abort, cnt_inc, cnt_clr;
    logic [CW-1:0]            cnt_q;
    logic                     write_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [BUS_WIDTH-1:0]     wdata_q;
    logic [BUS_WIDTH/8-1:0]   strb_q;
    logic [BUS_WIDTH-1:0]     rdata_q;
    logic                     err_q, timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cap_req  = 1'b0;
        cap_rsp  = 1'b0;
        to_abort = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cap_req = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY takes priority over an expiring counter in the same cycle
                if (pready_i) begin
                    cap_rsp = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYC > 0 && cnt_q == CNT_LAST) begin
                    to_abort = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (cap_req) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                strb_q  <= req_write_i ? req_strb_i : '0;
            end
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            if (cap_rsp) begin
                rdata_q   <= write_q ? '0 : prdata_i;
                err_q     <= pslverr_i;
                timeout_q <= 1'b0;
            end else if (to_abort) begin
                rdata_q   <= '0;
                err_q     <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign rsp_valid_o   = (state_q == RESP);
    assign pwrite_o      = write_q;
    assign paddr_o       = addr_q;
    assign pwdata_o      = wdata_q;
    assign pstrb_o       = strb_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// tb/tb_matmul_apb_master.sv - randomized bench for matmul_apb_master against a transaction-level model
module tb_matmul_apb_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        psel, penable, pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic        pready;
    logic [63:0] prdata;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_apb_master #(.BUS_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One command through the bus. The slave raises PREADY after wait_n wait
    // states; the model predicts the outcome from the timeout window alone.
    task automatic do_txn(input bit w, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, input int wait_n, input bit slv,
                          input logic [63:0] rd, input int hold);
        bit          exp_to   = (wait_n >= TO);
        int          exp_acc  = exp_to ? TO : wait_n + 1;
        logic [63:0] exp_rd   = (exp_to || w) ? 64'd0 : rd;
        bit          exp_err  = exp_to ? 1'b1 : slv;
        logic [7:0]  exp_strb = w ? s : 8'd0;
        int          acc = 0;
        bit          done = 0;
        logic [63:0] rd_seen;
        @(posedge clk); #1;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
        @(posedge clk); #1;
        req_valid = 0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
        req_strb = 8'($urandom); req_write = 1'($urandom);
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_pwrite", pwrite, w);
        chk("setup_paddr", paddr, a);
        chk("setup_pwdata", pwdata, d);
        chk("setup_pstrb", pstrb, exp_strb);
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) done = 1;
            else begin
                acc++;
                chk("access_penable", penable, 1);
                chk("access_psel", psel, 1);
                chk("access_paddr", paddr, a);
                chk("access_pwdata", pwdata, d);
                chk("access_pstrb", pstrb, exp_strb);
                pready  = (acc == wait_n + 1);
                prdata  = pready ? rd : {$urandom, $urandom};
                pslverr = pready ? slv : 1'($urandom);
            end
        end
        pready = 0; pslverr = 0;
        chk("rsp_arrived", 64'(done), 1);
        chk("access_cycles", 64'(acc), 64'(exp_acc));
        chk("resp_psel", psel, 0);
        chk("resp_penable", penable, 0);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_timeout, exp_to);
        rd_seen = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1;
            @(posedge clk); #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata_stable", rsp_rdata, rd_seen);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_no_psel", psel, 0);
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
    endtask

    initial begin
        rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        rsp_ready = 0; pready = 0; prdata = 0; pslverr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1;

        do_txn(1, 32'h0, 64'h0001_0002_0003_0004, 8'hFF, 0, 0, 64'h5555_AAAA_5555_AAAA, 0);
        do_txn(0, 32'h0000_0100, 64'h1111, 8'h0F, 3, 0, 64'hDEAD_BEEF_0000_1234, 0);
        do_txn(0, 32'h0000_0208, 64'h0, 8'hFF, 0, 1, 64'h0BAD_0BAD_0BAD_0BAD, 0);
        do_txn(0, 32'h0000_0010, 64'h0, 8'h00, 100, 0, 64'h1234, 0);
        do_txn(0, 32'h0000_0018, 64'h0, 8'h00, TO - 1, 0, 64'hCAFE_F00D_1234_5678, 0);
        do_txn(1, 32'h0000_0020, 64'hFEED, 8'h3C, 1, 0, 64'h0, 5);

        for (int i = 0; i < 12; i++)
            do_txn(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                   int'($urandom_range(0, 6)), 1'($urandom), {$urandom, $urandom},
                   int'($urandom_range(0, 3)));

        // Asynchronous reset while the slave is stalling in ACCESS.
        @(posedge clk); #1;
        req_valid = 1; req_write = 0; req_addr = 32'h40; req_strb = 8'hFF;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        chk("pre_rst_penable", penable, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        do_txn(0, 32'h0000_0080, 64'h0, 8'h00, 2, 0, 64'h0123_4567_89AB_CDEF, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
